i2c_arbiter: RTL and testbench
==============================

I2C_ARBITER -- requirements
Module: i2c_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 4: number of requesters sharing one I2C controller.
REQ-002 Parameter ADDR_WIDTH, default 7: slave address width.
REQ-003 Parameter DATA_WIDTH, default 8: data byte width.
REQ-004 Parameter TIMEOUT_CYCLES, default 65535: max cycles per transaction before abort.
REQ-005 clock  in  1  sole clock; all logic on rising edge.
REQ-006 reset  in  1  synchronous, active-high reset.
REQ-007 req_valid  in  NUM_REQ  per-requester request pending; held until accepted.
REQ-008 req_rw  in  NUM_REQ  per-requester direction: 1 = read, 0 = write.
REQ-009 req_addr  in  NUM_REQ*ADDR_WIDTH  per-requester slave address, packed, requester 0 in LSBs.
REQ-010 req_data  in  NUM_REQ*DATA_WIDTH  per-requester write byte, packed.
REQ-011 req_accept  out  NUM_REQ  one-hot, one-cycle pulse: request captured.
REQ-012 rsp_valid  out  NUM_REQ  one-hot, one-cycle pulse: transaction finished for that requester.
REQ-013 rsp_data  out  DATA_WIDTH  read byte; valid with rsp_valid; 0 for writes.
REQ-014 rsp_ack_error  out  1  slave NACK seen; valid with rsp_valid.
REQ-015 rsp_timeout  out  1  transaction aborted by timeout; valid with rsp_valid.
REQ-016 ctl_rw, ctl_slave_addr, ctl_tx_data  out  1/ADDR_WIDTH/DATA_WIDTH  registered command to I2C controller.
REQ-017 ctl_ready  out  1  one-cycle start pulse to I2C controller.
REQ-018 ctl_busy, ctl_valid, ctl_ack_error  in  1 each; ctl_rx_data  in  DATA_WIDTH: I2C controller status.
REQ-019 owner  out  $clog2(NUM_REQ)  index of requester currently served.

Function
REQ-020 FSM states IDLE, ISSUE, WAIT_BUSY, WAIT_DONE, RESPOND.
REQ-021 IDLE: if any req_valid, grant lowest index at or after rr_ptr (wrap-around); pulse req_accept[g], latch rw/addr/data into ctl_* and g into owner; go ISSUE.
REQ-022 ISSUE: ctl_ready=1 for exactly one cycle; clear timeout counter; go WAIT_BUSY.
REQ-023 WAIT_BUSY: on ctl_busy=1 go WAIT_DONE.
REQ-024 WAIT_DONE: on ctl_valid=1 capture ctl_rx_data; on ctl_busy falling (1->0) capture ctl_ack_error, go RESPOND.
REQ-025 Timeout counter increments each cycle in WAIT_BUSY/WAIT_DONE; on reaching TIMEOUT_CYCLES-1 go RESPOND with rsp_timeout=1.
REQ-026 RESPOND: pulse rsp_valid[owner] one cycle with rsp_data/rsp_ack_error/rsp_timeout; set rr_ptr = owner+1 mod NUM_REQ; go IDLE.
REQ-027 Accept-to-ctl_ready latency exactly 1 cycle; busy-fall-to-rsp_valid latency exactly 1 cycle.
REQ-028 ctl_rw/ctl_slave_addr/ctl_tx_data stable from ISSUE through RESPOND.
REQ-029 req_valid changes outside IDLE ignored; no new grant until return to IDLE.
REQ-030 Simultaneous requests: exactly one granted per transaction; a continuously requesting port waits at most NUM_REQ-1 transactions.
REQ-031 ctl_valid and busy fall in same cycle: data captured and RESPOND entered that cycle.
REQ-032 Write transactions return rsp_data=0.

Reset
REQ-033 On reset: state IDLE, rr_ptr 0, owner 0, all req_accept/rsp_valid/ctl_ready 0, rsp_data/rsp_ack_error/rsp_timeout 0, ctl_* 0, counter 0.
REQ-034 Reset mid-transaction abandons it with no rsp_valid pulse; first post-reset grant uses rr_ptr 0.

Structure
REQ-035 Package i2c_pkg holds arb_state_t enum and default width constants, shared with the I2C controller.
REQ-036 One combinational sub-module rr_arbiter (req vector, ptr -> one-hot grant, index, any).

Verification
REQ-037 Single write: req_valid[2], addr 0x50, data 0xA5; controller model ACKs -> ctl_ready 1 cycle after accept, rsp_valid[2], ack_error 0, rsp_data 0x00.
REQ-038 Single read: req 1, addr 0x3C; model returns 0x7E -> rsp_valid[1], rsp_data 0x7E.
REQ-039 All four request at once from reset -> grant order 0,1,2,3; then 1 and 3 re-request after 0 served -> next 1 then 3.
REQ-040 NACK: model ends with ctl_ack_error=1 -> rsp_ack_error 1, rsp_timeout 0.
REQ-041 Timeout: TIMEOUT_CYCLES=16, model never raises busy -> rsp_valid 16 cycles after ISSUE, rsp_timeout 1, FSM back to IDLE.
REQ-042 Reset asserted in WAIT_DONE -> no rsp_valid; all outputs zero next cycle.

Source files
------------

// File: rtl/i2c_pkg.sv
// Shared definitions for the I2C arbiter and the I2C controller it fronts.
// Latency: n/a (types, constants and a helper function only).
// Backpressure: n/a.
package i2c_pkg;

  localparam int DEF_NUM_REQ        = 4;
  localparam int DEF_ADDR_WIDTH     = 7;
  localparam int DEF_DATA_WIDTH     = 8;
  localparam int DEF_TIMEOUT_CYCLES = 65535;

  typedef enum logic [2:0] {
    ARB_IDLE      = 3'd0,
    ARB_ISSUE     = 3'd1,
    ARB_WAIT_BUSY = 3'd2,
    ARB_WAIT_DONE = 3'd3,
    ARB_RESPOND   = 3'd4
  } arb_state_t;

  // (base + off) mod n, valid for base < n and off < n.
  function automatic int wrap_idx(input int base, input int off, input int n);
    int s;
    s = base + off;
    return (s >= n) ? (s - n) : s;
  endfunction

endpackage

// File: rtl/i2c_arbiter_rr.sv
// Round-robin picker: lowest requesting index at or after ptr, with wrap-around.
// Latency: purely combinational.
// Backpressure: none; caller decides when the grant is consumed.
// Ports: req (request vector), ptr (search start) -> grant (one-hot), idx (binary), any.
module rr_arbiter
  import i2c_pkg::*;
#(
  parameter int NUM_REQ = DEF_NUM_REQ,
  parameter int IDX_W   = $clog2(DEF_NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDX_W-1:0]   idx,
  output logic               any
);

  logic [IDX_W-1:0] k;

  always_comb begin
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    k     = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      k = IDX_W'(wrap_idx(int'(ptr), i, NUM_REQ));
      if (!any && req[k]) begin
        any      = 1'b1;
        idx      = k;
        grant[k] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/i2c_arbiter.sv
// Shares one I2C controller among NUM_REQ requesters, one transaction at a time, round-robin.
// Latency: accept -> ctl_ready 1 cycle; controller busy fall -> rsp_valid 1 cycle.
// Backpressure: requesters hold req_valid until req_accept; no new grant until the current response.
// Ports: req_* (per-requester command, packed, requester 0 in LSBs), req_accept/rsp_* (one-hot pulses
//        and response payload), ctl_* (registered command + start pulse out, controller status in), owner.
module i2c_arbiter
  import i2c_pkg::*;
#(
  parameter int NUM_REQ        = DEF_NUM_REQ,
  parameter int ADDR_WIDTH     = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH     = DEF_DATA_WIDTH,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic [NUM_REQ-1:0]             req_valid,
  input  logic [NUM_REQ-1:0]             req_rw,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0]  req_addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]  req_data,
  output logic [NUM_REQ-1:0]             req_accept,
  output logic [NUM_REQ-1:0]             rsp_valid,
  output logic [DATA_WIDTH-1:0]          rsp_data,
  output logic                           rsp_ack_error,
  output logic                           rsp_timeout,
  output logic                           ctl_rw,
  output logic [ADDR_WIDTH-1:0]          ctl_slave_addr,
  output logic [DATA_WIDTH-1:0]          ctl_tx_data,
  output logic                           ctl_ready,
  input  logic                           ctl_busy,
  input  logic                           ctl_valid,
  input  logic                           ctl_ack_error,
  input  logic [DATA_WIDTH-1:0]          ctl_rx_data,
  output logic [$clog2(NUM_REQ)-1:0]     owner
);

  localparam int IDX_W = $clog2(NUM_REQ);
  localparam int CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  arb_state_t             state;
  logic [IDX_W-1:0]       rr_ptr;
  logic [CNT_W-1:0]       tmo_cnt;
  logic [CNT_W-1:0]       tmo_cnt_nxt;
  logic                   tmo_hit;
  logic                   busy_q;
  logic                   busy_fall;
  logic [DATA_WIDTH-1:0]  rx_hold;
  logic [DATA_WIDTH-1:0]  read_byte;
  logic [NUM_REQ-1:0]     owner_onehot;

  logic [NUM_REQ-1:0]     grant;
  logic [IDX_W-1:0]       grant_idx;
  logic                   grant_any;
  logic                   sel_rw;
  logic [ADDR_WIDTH-1:0]  sel_addr;
  logic [DATA_WIDTH-1:0]  sel_data;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_rr (
    .req   (req_valid),
    .ptr   (rr_ptr),
    .grant (grant),
    .idx   (grant_idx),
    .any   (grant_any)
  );

  // One-hot grant makes an AND-OR mux over the packed request fields.
  always_comb begin
    sel_rw   = 1'b0;
    sel_addr = '0;
    sel_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) begin
        sel_rw   = req_rw[i];
        sel_addr = req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
        sel_data = req_data[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  assign owner_onehot = NUM_REQ'(1) << owner;
  assign tmo_cnt_nxt  = tmo_cnt + CNT_W'(1);
  // Abort on the edge where the counter would reach TIMEOUT_CYCLES-1, so the
  // response lands TIMEOUT_CYCLES cycles after ISSUE.
  assign tmo_hit      = (tmo_cnt_nxt == CNT_LAST);
  assign busy_fall    = busy_q & ~ctl_busy;
  // A byte arriving in the same cycle busy drops wins over the held one.
  assign read_byte    = ctl_valid ? ctl_rx_data : rx_hold;

  always_ff @(posedge clock) begin
    if (reset) begin
      state          <= ARB_IDLE;
      rr_ptr         <= '0;
      owner          <= '0;
      req_accept     <= '0;
      rsp_valid      <= '0;
      rsp_data       <= '0;
      rsp_ack_error  <= 1'b0;
      rsp_timeout    <= 1'b0;
      ctl_rw         <= 1'b0;
      ctl_slave_addr <= '0;
      ctl_tx_data    <= '0;
      ctl_ready      <= 1'b0;
      tmo_cnt        <= '0;
      busy_q         <= 1'b0;
      rx_hold        <= '0;
    end else begin
      req_accept <= '0;
      ctl_ready  <= 1'b0;
      rsp_valid  <= '0;
      busy_q     <= ctl_busy;

      case (state)
        ARB_IDLE: begin
          if (grant_any) begin
            req_accept     <= grant;
            owner          <= grant_idx;
            ctl_rw         <= sel_rw;
            ctl_slave_addr <= sel_addr;
            ctl_tx_data    <= sel_data;
            state          <= ARB_ISSUE;
          end
        end

        ARB_ISSUE: begin
          ctl_ready <= 1'b1;
          tmo_cnt   <= '0;
          rx_hold   <= '0;
          state     <= ARB_WAIT_BUSY;
        end

        ARB_WAIT_BUSY: begin
          tmo_cnt <= tmo_cnt_nxt;
          if (tmo_hit) begin
            rsp_valid   <= owner_onehot;
            rsp_timeout <= 1'b1;
            state       <= ARB_RESPOND;
          end else if (ctl_busy) begin
            state <= ARB_WAIT_DONE;
          end
        end

        ARB_WAIT_DONE: begin
          tmo_cnt <= tmo_cnt_nxt;
          if (ctl_valid) begin
            rx_hold <= ctl_rx_data;
          end
          // A normal completion beats a timeout landing on the same cycle.
          if (busy_fall) begin
            rsp_valid     <= owner_onehot;
            rsp_data      <= ctl_rw ? read_byte : '0;
            rsp_ack_error <= ctl_ack_error;
            state         <= ARB_RESPOND;
          end else if (tmo_hit) begin
            rsp_valid   <= owner_onehot;
            rsp_timeout <= 1'b1;
            state       <= ARB_RESPOND;
          end
        end

        ARB_RESPOND: begin
          rsp_data      <= '0;
          rsp_ack_error <= 1'b0;
          rsp_timeout   <= 1'b0;
          rr_ptr        <= (owner == IDX_W'(NUM_REQ - 1)) ? '0 : owner + IDX_W'(1);
          state         <= ARB_IDLE;
        end

        default: state <= ARB_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_i2c_arbiter.sv
// Directed bench for i2c_arbiter: vector table of single transactions plus
// hand-written grant-order, timeout and mid-transaction reset sequences.
module tb_i2c_arbiter;

  localparam int NR = 4;
  localparam int AW = 7;
  localparam int DW = 8;

  logic              clock = 1'b0;
  logic              reset;
  logic [NR-1:0]     req_valid;
  logic [NR-1:0]     req_rw;
  logic [NR*AW-1:0]  req_addr;
  logic [NR*DW-1:0]  req_data;
  logic [NR-1:0]     req_accept;
  logic [NR-1:0]     rsp_valid;
  logic [DW-1:0]     rsp_data;
  logic              rsp_ack_error;
  logic              rsp_timeout;
  logic              ctl_rw;
  logic [AW-1:0]     ctl_slave_addr;
  logic [DW-1:0]     ctl_tx_data;
  logic              ctl_ready;
  logic              ctl_busy;
  logic              ctl_valid;
  logic              ctl_ack_error;
  logic [DW-1:0]     ctl_rx_data;
  logic [1:0]        owner;

  i2c_arbiter #(
    .NUM_REQ        (NR),
    .ADDR_WIDTH     (AW),
    .DATA_WIDTH     (DW),
    .TIMEOUT_CYCLES (16)
  ) dut (
    .clock          (clock),
    .reset          (reset),
    .req_valid      (req_valid),
    .req_rw         (req_rw),
    .req_addr       (req_addr),
    .req_data       (req_data),
    .req_accept     (req_accept),
    .rsp_valid      (rsp_valid),
    .rsp_data       (rsp_data),
    .rsp_ack_error  (rsp_ack_error),
    .rsp_timeout    (rsp_timeout),
    .ctl_rw         (ctl_rw),
    .ctl_slave_addr (ctl_slave_addr),
    .ctl_tx_data    (ctl_tx_data),
    .ctl_ready      (ctl_ready),
    .ctl_busy       (ctl_busy),
    .ctl_valid      (ctl_valid),
    .ctl_ack_error  (ctl_ack_error),
    .ctl_rx_data    (ctl_rx_data),
    .owner          (owner)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int n_vec = 0;
  int n_bad = 0;

  // Controller model configuration (written by the main thread only).
  logic          mdl_silent = 1'b0;
  logic          mdl_nack   = 1'b0;
  logic          mdl_vfall  = 1'b0;
  logic [DW-1:0] mdl_rx     = '0;
  int            fall_cyc   = 0;

  // Controller model: one cycle after ctl_ready raises busy for a few cycles,
  // delivers the read byte either inside busy or together with the busy fall.
  initial begin
    ctl_busy = 1'b0; ctl_valid = 1'b0; ctl_ack_error = 1'b0; ctl_rx_data = '0;
    forever begin
      @(negedge clock);
      if (ctl_ready && !mdl_silent) begin
        @(negedge clock);
        ctl_busy = 1'b1;
        repeat (2) @(negedge clock);
        if (!mdl_vfall) begin
          ctl_valid = 1'b1; ctl_rx_data = mdl_rx;
          @(negedge clock);
          ctl_valid = 1'b0;
        end
        ctl_busy = 1'b0; ctl_ack_error = mdl_nack; fall_cyc = cyc;
        if (mdl_vfall) begin
          ctl_valid = 1'b1; ctl_rx_data = mdl_rx;
        end
        @(negedge clock);
        ctl_valid = 1'b0; ctl_ack_error = 1'b0; ctl_rx_data = '0;
      end
    end
  end

  // Event logs filled by step().
  logic [NR-1:0] acc_vec[$];
  int            acc_cyc[$];
  int            rdy_cyc[$];
  logic          rdy_rw[$];
  logic [AW-1:0] rdy_addr[$];
  logic [DW-1:0] rdy_data[$];
  logic [NR-1:0] rsp_vec[$];
  int            rsp_cyc[$];
  logic [DW-1:0] rsp_dat[$];
  logic          rsp_ack[$];
  logic          rsp_tmo[$];
  logic [1:0]    rsp_own[$];
  logic [AW-1:0] rsp_addr[$];

  task automatic clear_logs();
    acc_vec.delete(); acc_cyc.delete(); rdy_cyc.delete(); rdy_rw.delete();
    rdy_addr.delete(); rdy_data.delete(); rsp_vec.delete(); rsp_cyc.delete();
    rsp_dat.delete(); rsp_ack.delete(); rsp_tmo.delete(); rsp_own.delete();
    rsp_addr.delete();
  endtask

  // Advance one cycle, sample outputs on the falling edge, drop accepted requests.
  task automatic step();
    @(negedge clock);
    if (req_accept != '0) begin
      acc_vec.push_back(req_accept);
      acc_cyc.push_back(cyc);
      req_valid = req_valid & ~req_accept;
    end
    if (ctl_ready) begin
      rdy_cyc.push_back(cyc); rdy_rw.push_back(ctl_rw);
      rdy_addr.push_back(ctl_slave_addr); rdy_data.push_back(ctl_tx_data);
    end
    if (rsp_valid != '0) begin
      rsp_vec.push_back(rsp_valid); rsp_cyc.push_back(cyc);
      rsp_dat.push_back(rsp_data); rsp_ack.push_back(rsp_ack_error);
      rsp_tmo.push_back(rsp_timeout); rsp_own.push_back(owner);
      rsp_addr.push_back(ctl_slave_addr);
    end
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic wait_rsp(input int n, input string what);
    int budget;
    budget = 200;
    while (rsp_vec.size() < n && budget > 0) begin
      step();
      budget--;
    end
    if (rsp_vec.size() < n) begin
      n_vec++; n_bad++;
      $display("FAIL %s: %0d responses seen, %0d expected", what, rsp_vec.size(), n);
    end
  endtask

  task automatic post(input int idx, input logic rw, input logic [AW-1:0] a, input logic [DW-1:0] d);
    req_rw[idx] = rw;
    req_addr[idx*AW +: AW] = a;
    req_data[idx*DW +: DW] = d;
    req_valid[idx] = 1'b1;
  endtask

  typedef struct {
    int            idx;
    logic          rw;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdat;
    logic [DW-1:0] rx;
    logic          nack;
    logic          vfall;
    logic [DW-1:0] exp_dat;
    logic          exp_ack;
  } vec_t;

  vec_t vt[5];

  initial begin
    #100000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "bench timed out");
  end

  initial begin
    //          idx rw  addr   wdat   rx     nack vfall exp_dat exp_ack
    vt[0] = '{2, 1'b0, 7'h50, 8'hA5, 8'hFF, 1'b0, 1'b0, 8'h00, 1'b0};  // write, ACK, rx ignored
    vt[1] = '{1, 1'b1, 7'h3C, 8'h00, 8'h7E, 1'b0, 1'b0, 8'h7E, 1'b0};  // read
    vt[2] = '{3, 1'b0, 7'h11, 8'h5A, 8'h00, 1'b1, 1'b0, 8'h00, 1'b1};  // write NACK
    vt[3] = '{0, 1'b1, 7'h7F, 8'h00, 8'hC3, 1'b0, 1'b1, 8'hC3, 1'b0};  // read, valid with busy fall
    vt[4] = '{2, 1'b1, 7'h01, 8'h33, 8'h81, 1'b1, 1'b0, 8'h81, 1'b1};  // read NACK

    reset = 1'b1; req_valid = '0; req_rw = '0; req_addr = '0; req_data = '0;
    repeat (3) step();
    check("rst_accept", req_accept, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_ctl_ready", ctl_ready, 0);
    check("rst_owner", owner, 0);
    check("rst_ctl_cmd", {ctl_rw, ctl_slave_addr, ctl_tx_data}, 0);
    check("rst_rsp_flags", {rsp_data, rsp_ack_error, rsp_timeout}, 0);
    reset = 1'b0;
    step();

    // All four request at once from reset: service in index order.
    clear_logs();
    for (int i = 0; i < NR; i++) post(i, 1'b0, AW'(7'h10 + i), DW'(8'h20 + i));
    wait_rsp(4, "rr_all4");
    for (int i = 0; i < NR; i++) begin
      check($sformatf("rr_all4_grant%0d", i), acc_vec[i], 32'(1) << i);
      check($sformatf("rr_all4_rsp%0d", i), rsp_vec[i], 32'(1) << i);
    end
    check("rr_all4_addr3", rdy_addr[3], 7'h13);

    // Requesters 1 and 3 then 1 goes first.
    clear_logs();
    post(1, 1'b0, 7'h21, 8'h01);
    post(3, 1'b0, 7'h23, 8'h03);
    wait_rsp(2, "rr_1_3");
    check("rr_1_3_first", acc_vec[0], 4'b0010);
    check("rr_1_3_second", acc_vec[1], 4'b1000);

    // 0 re-requests while it is being served: ignored, then 2 wins over it.
    clear_logs();
    post(0, 1'b0, 7'h30, 8'h00);
    post(2, 1'b0, 7'h32, 8'h02);
    for (int b = 0; b < 20 && acc_vec.size() == 0; b++) step();
    req_valid[0] = 1'b1;
    wait_rsp(3, "rr_fair");
    check("rr_fair_g0", acc_vec[0], 4'b0001);
    check("rr_fair_g1", acc_vec[1], 4'b0100);
    check("rr_fair_g2", acc_vec[2], 4'b0001);

    // Table of single transactions.
    for (int v = 0; v < 5; v++) begin
      clear_logs();
      mdl_rx = vt[v].rx; mdl_nack = vt[v].nack; mdl_vfall = vt[v].vfall;
      post(vt[v].idx, vt[v].rw, vt[v].addr, vt[v].wdat);
      wait_rsp(1, $sformatf("v%0d_rsp", v));
      check($sformatf("v%0d_accept", v), acc_vec[0], 32'(1) << vt[v].idx);
      check($sformatf("v%0d_ready_lat", v), rdy_cyc[0] - acc_cyc[0], 1);
      check($sformatf("v%0d_ctl_rw", v), rdy_rw[0], vt[v].rw);
      check($sformatf("v%0d_ctl_addr", v), rdy_addr[0], vt[v].addr);
      check($sformatf("v%0d_ctl_tx", v), rdy_data[0], vt[v].wdat);
      check($sformatf("v%0d_rsp_valid", v), rsp_vec[0], 32'(1) << vt[v].idx);
      check($sformatf("v%0d_rsp_lat", v), rsp_cyc[0] - fall_cyc, 1);
      check($sformatf("v%0d_rsp_data", v), rsp_dat[0], vt[v].exp_dat);
      check($sformatf("v%0d_ack_err", v), rsp_ack[0], vt[v].exp_ack);
      check($sformatf("v%0d_timeout", v), rsp_tmo[0], 0);
      check($sformatf("v%0d_owner", v), rsp_own[0], vt[v].idx);
      check($sformatf("v%0d_addr_held", v), rsp_addr[0], vt[v].addr);
    end
    mdl_nack = 1'b0; mdl_vfall = 1'b0;

    // Timeout: controller never goes busy.
    clear_logs();
    mdl_silent = 1'b1;
    post(1, 1'b1, 7'h22, 8'h00);
    wait_rsp(1, "tmo_rsp");
    check("tmo_rsp_valid", rsp_vec[0], 4'b0010);
    check("tmo_flag", rsp_tmo[0], 1);
    check("tmo_ack_err", rsp_ack[0], 0);
    check("tmo_latency", rsp_cyc[0] - acc_cyc[0], 16);
    mdl_silent = 1'b0;
    mdl_rx = 8'h3D;
    clear_logs();
    post(1, 1'b1, 7'h22, 8'h00);
    step(); step();
    check("tmo_idle_regrant", acc_vec.size(), 1);
    wait_rsp(1, "tmo_follow");
    check("tmo_follow_data", rsp_dat[0], 8'h3D);
    check("tmo_follow_flag", rsp_tmo[0], 0);

    // Reset while waiting for the controller to finish (rr_ptr is 2 here).
    clear_logs();
    post(2, 1'b0, 7'h44, 8'h55);
    for (int b = 0; b < 20 && rdy_cyc.size() == 0; b++) step();
    repeat (3) step();
    reset = 1'b1;
    step();
    check("midrst_outputs", {req_accept, rsp_valid, ctl_ready, owner}, 0);
    check("midrst_ctl", {ctl_rw, ctl_slave_addr, ctl_tx_data}, 0);
    check("midrst_rsp", {rsp_data, rsp_ack_error, rsp_timeout}, 0);
    reset = 1'b0;
    repeat (10) step();
    check("midrst_no_rsp", rsp_vec.size(), 0);

    // First grant after reset starts from index 0 again.
    clear_logs();
    post(1, 1'b0, 7'h61, 8'h11);
    post(3, 1'b0, 7'h63, 8'h33);
    wait_rsp(2, "postrst");
    check("postrst_first", acc_vec[0], 4'b0010);
    check("postrst_second", acc_vec[1], 4'b1000);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
